// File: rtl/ram_arbiter.sv
// Single-port RAM arbiter: the core owns every cycle it strobes, DMA commands
// queue in a small FIFO and drain only into cycles the core leaves idle.
module ram_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [ADDR_W-1:0]             cpu_addr,
  input  logic                          cpu_rstrb,
  input  logic [31:0]                   cpu_wdata,
  input  logic [3:0]                    cpu_wmask,
  output logic [31:0]                   cpu_rdata,
  input  logic                          dma_valid,
  output logic                          dma_ready,
  input  logic [ADDR_W-1:0]             dma_addr,
  input  logic [31:0]                   dma_wdata,
  input  logic [3:0]                    dma_wmask,
  output logic                          dma_rvalid,
  output logic [31:0]                   dma_rdata,
  output logic [$clog2(FIFO_DEPTH):0]   dma_pending,
  output logic [ADDR_W-1:0]             ram_addr,
  output logic                          ram_rstrb,
  output logic [31:0]                   ram_wdata,
  output logic [3:0]                    ram_wmask,
  input  logic [31:0]                   ram_rdata
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] DEPTH_C = FIFO_DEPTH[PW:0];

  logic [ADDR_W-1:0] r_q_addr  [FIFO_DEPTH];
  logic [31:0]       r_q_wdata [FIFO_DEPTH];
  logic [3:0]        r_q_wmask [FIFO_DEPTH];
  logic [PW-1:0]     r_wptr, r_rptr;
  logic [PW:0]       r_count;
  logic              r_rd_issued, r_owner_dma;
  logic [31:0]       r_cpu_hold;

  logic w_cpu_busy, w_empty, w_full, w_push, w_pop, w_dma_rd, w_dma_rvalid;

  assign w_cpu_busy   = cpu_rstrb | (|cpu_wmask);
  assign w_empty      = (r_count == '0);
  assign w_full       = (r_count == DEPTH_C);
  // Readiness uses the pre-pop level: a full FIFO never accepts, even while draining.
  assign w_push       = dma_valid & ~w_full;
  assign w_pop        = ~w_empty & ~w_cpu_busy;
  assign w_dma_rd     = w_pop & (r_q_wmask[r_rptr] == 4'b0000);
  assign w_dma_rvalid = r_rd_issued & r_owner_dma;

  always_comb begin
    ram_addr  = cpu_addr;
    ram_wdata = cpu_wdata;
    ram_wmask = 4'b0000;
    ram_rstrb = 1'b0;
    if (w_cpu_busy) begin
      ram_wmask = cpu_wmask;
      ram_rstrb = cpu_rstrb;
    end else if (!w_empty) begin
      ram_addr  = r_q_addr[r_rptr];
      ram_wdata = r_q_wdata[r_rptr];
      ram_wmask = r_q_wmask[r_rptr];
      ram_rstrb = (r_q_wmask[r_rptr] == 4'b0000);
    end
  end

  // Command storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_addr[r_wptr]  <= dma_addr;
      r_q_wdata[r_wptr] <= dma_wdata;
      r_q_wmask[r_wptr] <= dma_wmask;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_rd_issued <= 1'b0;
      r_owner_dma <= 1'b0;
      r_cpu_hold  <= 32'h0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      r_rd_issued <= ram_rstrb;
      if (ram_rstrb) r_owner_dma <= w_dma_rd;
      // Snapshot the core's word so a later DMA read cannot overwrite what it sees.
      if (r_rd_issued && !r_owner_dma) r_cpu_hold <= ram_rdata;
    end
  end

  assign cpu_rdata   = r_owner_dma ? r_cpu_hold : ram_rdata;
  assign dma_ready   = ~w_full;
  assign dma_rvalid  = w_dma_rvalid;
  assign dma_rdata   = ram_rdata;
  assign dma_pending = r_count + {{PW{1'b0}}, w_dma_rvalid};
endmodule
